// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration-time helpers for the FIFO family.
package fifo_pkg;

  localparam int unsigned DefDataSize = 8;
  localparam int unsigned DefAddrSize = 4;
  localparam int unsigned DefMemDepth = 16;
  localparam int unsigned DefPtrWidth = DefAddrSize + 1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read, no reset on contents.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE  = DefDataSize,
  parameter int unsigned MEM_DEPTH = DefMemDepth,
  parameter int unsigned ADDRSIZE  = clog2(MEM_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_wr_en,
  input  logic [ADDRSIZE-1:0] i_wr_addr,
  input  logic [DATASIZE-1:0] i_wr_data,
  input  logic [ADDRSIZE-1:0] i_rd_addr,
  output logic [DATASIZE-1:0] o_rd_data
);

  logic [DATASIZE-1:0] r_mem [MEM_DEPTH];

  // Store the accepted write word.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Async read lets FWFT present the head word without an extra stage.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable thresholds, flush, sticky errors and
// selectable standard / first-word-fall-through read behaviour.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE  = DefDataSize,
  parameter int unsigned ADDRSIZE  = DefAddrSize,
  parameter int unsigned MEM_DEPTH = DefMemDepth,
  parameter int unsigned FWFT      = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATASIZE-1:0]   i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATASIZE-1:0]   o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_flush,
  input  logic [ADDRSIZE:0]     i_afull_thresh,
  input  logic [ADDRSIZE:0]     i_aempty_thresh,
  input  logic                  i_clr_err,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDRSIZE:0]     o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned PtrW = ptr_width(ADDRSIZE);

  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic                r_overflow;
  logic                r_underflow;
  logic                w_full;
  logic                w_empty;
  logic [PtrW-1:0]     w_count;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_wr_err;
  logic                w_rd_err;
  logic [DATASIZE-1:0] w_ram_rdata;

  // Status decode from the registered pointers, plus acceptance qualification.
  always_comb begin
    w_empty  = (r_wr_ptr == r_rd_ptr);
    w_full   = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) &&
               (r_wr_ptr[PtrW-2:0] == r_rd_ptr[PtrW-2:0]);
    w_count  = r_wr_ptr - r_rd_ptr;
    // Flush swallows same-cycle requests, including their error side effects.
    w_wr_acc = i_wr_en && !w_full && !i_flush;
    w_rd_acc = i_rd_en && !w_empty && !i_flush;
    w_wr_err = i_wr_en && w_full && !i_flush;
    w_rd_err = i_rd_en && w_empty && !i_flush;
  end

  // Pointer registers; flush returns both to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  // Sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_err)       r_overflow  <= 1'b1;
      else if (i_clr_err) r_overflow  <= 1'b0;
      if (w_rd_err)       r_underflow <= 1'b1;
      else if (i_clr_err) r_underflow <= 1'b0;
    end
  end

  fifo_ram #(
    .DATASIZE  (DATASIZE),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDRSIZE  (ADDRSIZE)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[PtrW-2:0]),
    .i_wr_data (i_wr_data),
    .i_rd_addr (r_rd_ptr[PtrW-2:0]),
    .o_rd_data (w_ram_rdata)
  );

  if (FWFT == 0) begin : g_std
    logic [DATASIZE-1:0] r_rd_data;
    logic                r_rd_valid;

    // Registered read: capture the head on an accepted pop, valid for one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= w_ram_rdata;
      end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
  end else begin : g_fwft
    // Head word shown directly; masked to zero while empty so reset reads 0.
    assign o_rd_data  = w_empty ? '0 : w_ram_rdata;
    assign o_rd_valid = !w_empty;
  end

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_count        = w_count;
  assign o_almost_full  = (w_count >= i_afull_thresh);
  assign o_almost_empty = (w_count <= i_aempty_thresh);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog: vector table plus wrap, FWFT, flush and
// mid-stream reset sequences.
module tb_fifo_sync_prog;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       flush;
  logic [4:0] afull_thresh;
  logic [4:0] aempty_thresh;
  logic       clr_err;

  logic [7:0] rd_data;
  logic       rd_valid, full, empty, afull, aempty, ovf, unf;
  logic [4:0] count;

  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [4:0] f_count;

  int total = 0;
  int bad   = 0;

  fifo_sync_prog #(.DATASIZE(8), .ADDRSIZE(4), .MEM_DEPTH(16), .FWFT(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_flush(flush),
    .i_afull_thresh(afull_thresh), .i_aempty_thresh(aempty_thresh), .i_clr_err(clr_err),
    .o_full(full), .o_empty(empty), .o_almost_full(afull), .o_almost_empty(aempty),
    .o_count(count), .o_overflow(ovf), .o_underflow(unf)
  );

  fifo_sync_prog #(.DATASIZE(8), .ADDRSIZE(4), .MEM_DEPTH(16), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
    .o_rd_data(f_rd_data), .o_rd_valid(f_rd_valid), .i_flush(flush),
    .i_afull_thresh(afull_thresh), .i_aempty_thresh(aempty_thresh), .i_clr_err(clr_err),
    .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_afull), .o_almost_empty(f_aempty),
    .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       fl;
    logic       clr;
    logic [4:0] aft;
    logic [4:0] aet;
    logic       noclk;
    logic [4:0] e_count;
    logic       e_full;
    logic       e_empty;
    logic       e_af;
    logic       e_ae;
    logic       e_vld;
    logic [7:0] e_data;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic wr, input logic [7:0] wd, input logic rd,
                     input logic fl, input logic clr, input logic [4:0] aft,
                     input logic [4:0] aet, input logic noclk, input logic [4:0] e_count,
                     input logic e_full, input logic e_empty, input logic e_af,
                     input logic e_ae, input logic e_vld, input logic [7:0] e_data,
                     input logic e_ovf, input logic e_unf);
    vec_t v;
    v.name = name; v.wr = wr; v.wd = wd; v.rd = rd; v.fl = fl; v.clr = clr;
    v.aft = aft; v.aet = aet; v.noclk = noclk; v.e_count = e_count; v.e_full = e_full;
    v.e_empty = e_empty; v.e_af = e_af; v.e_ae = e_ae; v.e_vld = e_vld;
    v.e_data = e_data; v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endtask

  // Reset values on both instances; thresholds must be 16 / 0 when called.
  task automatic chk_rst(input string tag);
    chk({tag, "/count"}, 32'(count), 0);
    chk({tag, "/empty"}, 32'(empty), 1);
    chk({tag, "/full"}, 32'(full), 0);
    chk({tag, "/aempty"}, 32'(aempty), 1);
    chk({tag, "/afull"}, 32'(afull), 0);
    chk({tag, "/rd_data"}, 32'(rd_data), 0);
    chk({tag, "/rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "/ovf"}, 32'(ovf), 0);
    chk({tag, "/unf"}, 32'(unf), 0);
    chk({tag, "/f_count"}, 32'(f_count), 0);
    chk({tag, "/f_empty"}, 32'(f_empty), 1);
    chk({tag, "/f_full"}, 32'(f_full), 0);
    chk({tag, "/f_aempty"}, 32'(f_aempty), 1);
    chk({tag, "/f_afull"}, 32'(f_afull), 0);
    chk({tag, "/f_rd_data"}, 32'(f_rd_data), 0);
    chk({tag, "/f_rd_valid"}, 32'(f_rd_valid), 0);
    chk({tag, "/f_ovf"}, 32'(f_ovf), 0);
    chk({tag, "/f_unf"}, 32'(f_unf), 0);
  endtask

  // One clocked cycle against a queue reference model.
  task automatic cyc(input bit wr, input bit rd);
    logic [7:0] d;
    logic [7:0] exp;
    bit         wa;
    bit         ra;
    d   = 8'($urandom);
    exp = '0;
    wa  = wr && (q.size() < 16);
    ra  = rd && (q.size() > 0);
    if (ra) exp = q.pop_front();
    if (wa) q.push_back(d);
    wr_en = wr; wr_data = d; rd_en = rd;
    @(posedge clk); #1;
    chk("wrap/count", 32'(count), q.size());
    chk("wrap/count_le16", 32'(count <= 5'd16), 1);
    chk("wrap/rd_valid", 32'(rd_valid), 32'(ra));
    if (ra) chk("wrap/rd_data", 32'(rd_data), 32'(exp));
    if (q.size() > 0) chk("wrap/fwft_head", 32'(f_rd_data), 32'(q[0]));
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; wr_en = 0; wr_data = 0; rd_en = 0; flush = 0; clr_err = 0;
    afull_thresh = 5'd16; aempty_thresh = 5'd0;

    // Fill / overflow / drain, thresholds chosen so the almost flags track full/empty.
    add("rst_idle", 0, 8'h00, 0, 0, 0, 16, 0, 0, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++)
      add("fill", 1, 8'(i + 1), 0, 0, 0, 16, 0, 0, 5'(i + 1), i == 15, 0, i == 15, 0, 0,
          8'h00, 0, 0);
    add("ovf", 1, 8'hAA, 0, 0, 0, 16, 0, 0, 16, 1, 0, 1, 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++)
      add("drain", 0, 8'h00, 1, 0, 0, 16, 0, 0, 5'(15 - i), 0, i == 15, 0, i == 15, 1,
          8'(i + 1), 1, 0);
    add("hold", 0, 8'h00, 0, 0, 0, 16, 0, 0, 0, 0, 1, 0, 1, 0, 8'h10, 1, 0);
    // Simultaneous read/write at both boundaries.
    add("clr", 0, 8'h00, 0, 0, 1, 16, 0, 0, 0, 0, 1, 0, 1, 0, 8'h10, 0, 0);
    for (int i = 0; i < 16; i++)
      add("fill3", 1, 8'(8'h20 + i), 0, 0, 0, 16, 0, 0, 5'(i + 1), i == 15, 0, i == 15, 0, 0,
          8'h10, 0, 0);
    add("wr_rd_full", 1, 8'hBB, 1, 0, 0, 16, 0, 0, 15, 0, 0, 0, 0, 1, 8'h20, 1, 0);
    for (int i = 0; i < 15; i++)
      add("drain3", 0, 8'h00, 1, 0, 0, 16, 0, 0, 5'(14 - i), 0, i == 14, 0, i == 14, 1,
          8'(8'h21 + i), 1, 0);
    add("wr_rd_empty", 1, 8'h77, 1, 0, 0, 16, 0, 0, 1, 0, 0, 0, 0, 0, 8'h2F, 1, 1);
    add("clr2", 0, 8'h00, 0, 0, 1, 16, 0, 0, 1, 0, 0, 0, 0, 0, 8'h2F, 0, 0);
    add("rd77", 0, 8'h00, 1, 0, 0, 16, 0, 0, 0, 0, 1, 0, 1, 1, 8'h77, 0, 0);
    // Programmable thresholds, including same-cycle threshold changes.
    for (int i = 0; i < 12; i++)
      add("thr", 1, 8'(8'h40 + i), 0, 0, 0, 12, 3, 0, 5'(i + 1), 0, 0, (i + 1) >= 12,
          (i + 1) <= 3, 0, 8'h77, 0, 0);
    add("aft13", 0, 8'h00, 0, 0, 0, 13, 3, 1, 12, 0, 0, 0, 0, 0, 8'h77, 0, 0);
    add("aft0", 0, 8'h00, 0, 0, 0, 0, 3, 1, 12, 0, 0, 1, 0, 0, 8'h77, 0, 0);
    add("aet16", 0, 8'h00, 0, 0, 0, 13, 16, 1, 12, 0, 0, 0, 1, 0, 8'h77, 0, 0);
    // Flush beats a same-cycle write and read, without raising errors.
    add("flush", 1, 8'h99, 1, 1, 0, 16, 0, 0, 0, 0, 1, 0, 1, 0, 8'h77, 0, 0);

    #2;
    chk_rst("reset");
    #10 rst_n = 1'b1;

    foreach (vecs[k]) begin
      v = vecs[k];
      wr_en = v.wr; wr_data = v.wd; rd_en = v.rd; flush = v.fl; clr_err = v.clr;
      afull_thresh = v.aft; aempty_thresh = v.aet;
      if (v.noclk) #1;
      else begin
        @(posedge clk); #1;
      end
      chk({v.name, "/count"}, 32'(count), 32'(v.e_count));
      chk({v.name, "/full"}, 32'(full), 32'(v.e_full));
      chk({v.name, "/empty"}, 32'(empty), 32'(v.e_empty));
      chk({v.name, "/afull"}, 32'(afull), 32'(v.e_af));
      chk({v.name, "/aempty"}, 32'(aempty), 32'(v.e_ae));
      chk({v.name, "/rd_valid"}, 32'(rd_valid), 32'(v.e_vld));
      chk({v.name, "/rd_data"}, 32'(rd_data), 32'(v.e_data));
      chk({v.name, "/ovf"}, 32'(ovf), 32'(v.e_ovf));
      chk({v.name, "/unf"}, 32'(unf), 32'(v.e_unf));
    end
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;

    // Wrap-around: prefill, random interleave, drain.
    for (int i = 0; i < 10; i++) cyc(1, 0);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin cyc(1, 0); cyc(0, 1); end
        1: cyc(1, 1);
        default: begin cyc(1, 0); cyc(0, 0); cyc(0, 1); end
      endcase
    end
    for (int i = 0; i < 16; i++) cyc(0, 1);
    wr_en = 0; rd_en = 0;

    // FWFT behaviour, flush and mid-stream reset.
    rst_n = 1'b0; #2 rst_n = 1'b1;
    @(posedge clk); #1;
    wr_en = 1; wr_data = 8'h5A;
    @(posedge clk); #1;
    chk("fwft_5a/valid", 32'(f_rd_valid), 1);
    chk("fwft_5a/data", 32'(f_rd_data), 32'h5A);
    chk("fwft_5a/count", 32'(f_count), 1);
    wr_data = 8'h6B;
    @(posedge clk); #1;
    chk("fwft_6b/data", 32'(f_rd_data), 32'h5A);
    chk("fwft_6b/count", 32'(f_count), 2);
    wr_en = 0; rd_en = 1;
    @(posedge clk); #1;
    chk("fwft_rd/data", 32'(f_rd_data), 32'h6B);
    chk("fwft_rd/count", 32'(f_count), 1);
    chk("fwft_rd/valid", 32'(f_rd_valid), 1);
    chk("fwft_rd/std_data", 32'(rd_data), 32'h5A);
    rd_en = 0; flush = 1; wr_en = 1; wr_data = 8'h99;
    @(posedge clk); #1;
    chk("fwft_flush/empty", 32'(f_empty), 1);
    chk("fwft_flush/count", 32'(f_count), 0);
    chk("fwft_flush/valid", 32'(f_rd_valid), 0);
    chk("fwft_flush/ovf", 32'(f_ovf), 0);
    chk("fwft_flush/unf", 32'(f_unf), 0);
    flush = 0; wr_en = 0;
    @(posedge clk); #1;
    chk("fwft_post_flush/valid", 32'(f_rd_valid), 0);
    rd_en = 1;
    @(posedge clk); #1;
    chk("fwft_unf", 32'(f_unf), 1);
    rd_en = 0; wr_en = 1; wr_data = 8'h11;
    @(posedge clk); #1;
    chk("fwft_11/data", 32'(f_rd_data), 32'h11);
    chk("fwft_11/count", 32'(f_count), 1);
    wr_data = 8'h22;
    #3 rst_n = 1'b0;
    #1;
    chk_rst("mid_reset");
    wr_en = 0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
